// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: 2-flop sync, counter debounce, press/release pulses,
// toggle latch and long-press pulse per key. Channels share nothing but the clock and reset.
module key_debounce_multi #(
    parameter int N_KEYS        = 8,
    parameter int STABLE_CYCLES = 270000,
    parameter int HOLD_CYCLES   = 13500000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_toggle,
    output logic [N_KEYS-1:0] key_long
);

    localparam int DW = $clog2(STABLE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [N_KEYS-1:0] sync1_q, sync2_q;
    logic [N_KEYS-1:0] state_q, state_d;
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] release_q, release_d;
    logic [N_KEYS-1:0] toggle_q, toggle_d;
    logic [N_KEYS-1:0] long_q, long_d;
    logic [DW-1:0]     deb_cnt_q [N_KEYS];
    logic [DW-1:0]     deb_cnt_d [N_KEYS];
    logic [HW-1:0]     hold_cnt_q [N_KEYS];
    logic [HW-1:0]     hold_cnt_d [N_KEYS];

    always_comb begin
        state_d    = state_q;
        toggle_d   = toggle_q;
        press_d    = '0;
        release_d  = '0;
        long_d     = '0;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        for (int i = 0; i < N_KEYS; i++) begin
            // Any sample agreeing with the debounced level restarts the stability count.
            if (sync2_q[i] == state_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                deb_cnt_d[i] = '0;
                state_d[i]   = ~state_q[i];
                press_d[i]   = ~state_q[i];
                release_d[i] = state_q[i];
                if (!state_q[i]) begin
                    toggle_d[i] = ~toggle_q[i];
                end
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
            end

            if (!state_q[i]) begin
                hold_cnt_d[i] = '0;
            end else if (hold_cnt_q[i] != HOLD_MAX) begin
                hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
                long_d[i]     = (hold_cnt_q[i] == HOLD_LAST);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            toggle_q  <= '0;
            long_q    <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                deb_cnt_q[i]  <= '0;
                hold_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= key_raw;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
            long_q    <= long_d;
            for (int i = 0; i < N_KEYS; i++) begin
                deb_cnt_q[i]  <= deb_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
            end
        end
    end

    assign key_state   = state_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_toggle  = toggle_q;
    assign key_long    = long_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi with N_KEYS=4, STABLE_CYCLES=4, HOLD_CYCLES=20.
module tb_key_debounce_multi;

    logic       clock;
    logic       reset;
    logic [3:0] key_raw;
    logic [3:0] key_state, key_press, key_release, key_toggle, key_long;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] seen_state, seen_press, seen_release, seen_long, seen_both;
    int         cnt_press2, cnt_release2;

    key_debounce_multi #(
        .N_KEYS(4), .STABLE_CYCLES(4), .HOLD_CYCLES(20)
    ) dut (
        .clock(clock), .reset(reset), .key_raw(key_raw),
        .key_state(key_state), .key_press(key_press), .key_release(key_release),
        .key_toggle(key_toggle), .key_long(key_long)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_seen();
        seen_state = '0; seen_press = '0; seen_release = '0;
        seen_long = '0; seen_both = '0;
        cnt_press2 = 0; cnt_release2 = 0;
    endtask

    // Advance n rising edges, sampling 1 time unit after each edge.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            seen_state   |= key_state;
            seen_press   |= key_press;
            seen_release |= key_release;
            seen_long    |= key_long;
            seen_both    |= key_press & key_release;
            cnt_press2   += int'(key_press[2]);
            cnt_release2 += int'(key_release[2]);
        end
    endtask

    initial begin
        reset   = 1'b1;
        key_raw = '0;
        clear_seen();
        run(2);
        check("reset_outputs", {key_state, key_press, key_release, key_toggle, key_long}, 32'h0);
        reset = 1'b0;

        // Clean press on key 0, held 30 cycles
        key_raw[0] = 1'b1;
        run(5);
        check("clean_state_edge5", key_state, 4'b0000);
        run(1);
        check("clean_state_edge6", key_state, 4'b0001);
        check("clean_press", key_press, 4'b0001);
        check("clean_toggle", key_toggle, 4'b0001);
        clear_seen();
        run(1);
        check("clean_press_one_cycle", key_press, 4'b0000);
        run(18);
        check("clean_no_early_long", seen_long, 4'b0000);
        run(1);
        check("clean_long", key_long, 4'b0001);
        clear_seen();
        run(4);
        check("clean_long_once", seen_long, 4'b0000);
        key_raw[0] = 1'b0;
        run(5);
        check("clean_state_held", key_state, 4'b0001);
        run(1);
        check("clean_release", key_release, 4'b0001);
        check("clean_state_low", key_state, 4'b0000);
        check("clean_toggle_kept", key_toggle, 4'b0001);
        run(1);
        check("clean_release_one_cycle", key_release, 4'b0000);

        // Bounce on key 1: 1,1,1,0 repeated, then steady 1
        clear_seen();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                key_raw[1] = (k != 3);
                run(1);
            end
        end
        key_raw[1] = 1'b1;
        run(5);
        check("bounce_no_state", seen_state, 4'b0000);
        check("bounce_no_press", seen_press, 4'b0000);
        run(1);
        check("bounce_accept_state", key_state, 4'b0010);
        check("bounce_accept_press", key_press, 4'b0010);
        key_raw[1] = 1'b0;
        clear_seen();
        run(8);
        check("bounce_release", seen_release, 4'b0010);
        check("bounce_no_long", seen_long, 4'b0000);

        // Two press/release cycles on key 2
        clear_seen();
        key_raw[2] = 1'b1; run(10);
        key_raw[2] = 1'b0; run(10);
        check("toggle_after_first", key_toggle[2], 1'b1);
        key_raw[2] = 1'b1; run(10);
        key_raw[2] = 1'b0; run(10);
        check("toggle_after_second", key_toggle[2], 1'b0);
        check("press2_count", cnt_press2, 2);
        check("release2_count", cnt_release2, 2);
        check("press_release_exclusive", seen_both, 4'b0000);
        check("toggle_no_long", seen_long, 4'b0000);

        // All keys pressed in the same cycle
        key_raw = 4'b1111;
        run(5);
        check("simul_press_early", key_press, 4'b0000);
        run(1);
        check("simul_press", key_press, 4'b1111);
        check("simul_toggle", key_toggle, 4'b1100);
        run(1);
        check("simul_press_one_cycle", key_press, 4'b0000);
        key_raw = 4'b0000;
        run(5);
        check("simul_release_early", key_release, 4'b0000);
        run(1);
        check("simul_release", key_release, 4'b1111);
        run(1);
        check("simul_release_one_cycle", key_release, 4'b0000);

        // Reset in the middle of a hold on key 0
        key_raw[0] = 1'b1;
        run(10);
        check("midreset_pre_state", key_state, 4'b0001);
        reset = 1'b1;
        run(1);
        check("midreset_during1", {key_state, key_press, key_release, key_toggle, key_long}, 32'h0);
        run(1);
        check("midreset_during2", {key_state, key_press, key_release, key_toggle, key_long}, 32'h0);
        reset = 1'b0;
        clear_seen();
        run(5);
        check("midreset_no_early_press", seen_press, 4'b0000);
        run(1);
        check("midreset_press", key_press, 4'b0001);
        check("midreset_toggle", key_toggle, 4'b0001);
        clear_seen();
        run(19);
        check("midreset_no_early_long", seen_long, 4'b0000);
        run(1);
        check("midreset_long", key_long, 4'b0001);
        key_raw[0] = 1'b0;
        run(8);
        check("midreset_released", key_state, 4'b0000);

        // Single-cycle glitch on key 1
        clear_seen();
        key_raw[1] = 1'b1;
        run(1);
        key_raw[1] = 1'b0;
        run(12);
        check("glitch_state", seen_state, 4'b0000);
        check("glitch_press", seen_press, 4'b0000);
        check("glitch_release", seen_release, 4'b0000);
        check("glitch_long", seen_long, 4'b0000);
        check("glitch_toggle", key_toggle, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
- Parametrised N-channel push-button conditioner; successor to the direct key-to-LED wiring used in the button labs.
- Per key: 2-flop synchroniser, counter-based debounce, one-cycle press/release pulses, toggle latch and long-press detection.
- Sits between the board `key` bus and lab logic in `hackathon_top`; outputs feed LEDs, counters and FSMs directly.

Parameters:
- N_KEYS, 8, number of independent key channels.
- STABLE_CYCLES, 270000, consecutive clock cycles a synchronised input must differ from the debounced state before the state flips; must be >= 1.
- HOLD_CYCLES, 13500000, cycles `key_state` must stay 1 before `key_long` pulses; must be >= 1.

Ports:
- clock, input, 1, system clock; all logic is on its rising edge.
- reset, input, 1, synchronous, active-high; clears all state.
- key_raw, input, N_KEYS, asynchronous bouncing button levels; 1 = pressed.
- key_state, output, N_KEYS, debounced level.
- key_press, output, N_KEYS, one-cycle pulse on a debounced 0->1 transition.
- key_release, output, N_KEYS, one-cycle pulse on a debounced 1->0 transition.
- key_toggle, output, N_KEYS, level that inverts on every `key_press`.
- key_long, output, N_KEYS, one-cycle pulse when a hold reaches HOLD_CYCLES.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high; ports are named `clock` and `reset`.
- Reset: while `reset` is 1 at a rising edge, the following all become 0:
  - synchroniser flops, debounce counters and hold counters;
  - `key_state`, `key_press`, `key_release`, `key_toggle`, `key_long`.
- Channel independence: every channel has its own logic. There is no cross-channel interaction.
- Synchroniser: `key_raw[i]` passes through s1 then s2. Only s2 is used downstream.
- Debounce counter: width `$clog2(STABLE_CYCLES+1)`.
  - If s2 == `key_state`, the counter goes to 0.
  - Else if counter == STABLE_CYCLES-1, `key_state` inverts and the counter goes to 0.
  - Else the counter increments.
- Latency: from the first rising edge that samples a new stable `key_raw` level, `key_state` changes on edge STABLE_CYCLES+2. Example: STABLE_CYCLES=4 gives 6 edges.
- Bounce rejection: any cycle with s2 == `key_state` before the threshold restarts the count from 0. A glitch shorter than STABLE_CYCLES cycles never changes `key_state`.
- Press/release pulses: `key_press[i]` and `key_release[i]` are registered. Each is 1 for exactly the one cycle after the edge on which `key_state[i]` flipped. They are never both 1.
- Toggle: `key_toggle[i]` inverts on the same edge that sets `key_press[i]`. It is unaffected by release.
- Long-press counter:
  - Width `$clog2(HOLD_CYCLES+1)`.
  - Cleared whenever `key_state[i]` is 0; increments while it is 1; saturates at HOLD_CYCLES.
  - `key_long[i]` pulses for one cycle on the edge where the counter transitions HOLD_CYCLES-1 -> HOLD_CYCLES.
  - Fires at most once per hold and re-arms only after release.
  - A release before HOLD_CYCLES produces no `key_long`.
- Simultaneous events: multiple channels may pulse in the same cycle. Each channel's outputs are fully independent.
- Reset mid-operation: all in-flight counts are discarded. A key still held when reset deasserts is treated as a new press and produces `key_press` STABLE_CYCLES+2 edges later. `key_toggle` restarts from 0.
- Widths: counters never wrap. The debounce counter never exceeds STABLE_CYCLES-1; the hold counter saturates.
- Synthesis: fully synthesizable, no latches.

Test Plan (bench parameters: N_KEYS=4, STABLE_CYCLES=4, HOLD_CYCLES=20):
- Clean press: `key_raw[0]` 0->1 held 30 cycles -> `key_state[0]`=1 on the 6th edge; `key_press[0]` high exactly one cycle; `key_toggle[0]`=1; `key_long[0]` pulses once, 20 cycles after `key_state` rose; no second pulse while held.
- Bounce: `key_raw[1]` pattern 1,1,1,0,1,1,1,0 repeating, then steady 1 -> no `key_state`/`key_press` activity during the pattern; press accepted 6 edges after the steady 1 begins.
- Release and toggle: two full press/release cycles of 10 cycles each on `key_raw[2]` -> two `key_press` and two `key_release` pulses; `key_toggle[2]` goes 1 then 0; no `key_long`.
- Simultaneous keys: `key_raw[3:0]`=4'b1111 in the same cycle -> `key_press`=4'b1111 in the same single cycle; later `key_raw`=0 gives `key_release`=4'b1111 in one cycle.
- Mid-operation reset: hold `key_raw[0]`=1, assert `reset` for 2 cycles at hold cycle 10 -> all outputs 0 during reset; `key_press[0]` re-fires 6 edges after deassert; `key_long[0]` fires 20 cycles after that.
- Glitch: a single-cycle 1 on `key_raw[1]` -> all outputs remain 0.
